inert_intf: RTL
===============

# inert_intf

Front-end for the inertial sensor path. It powers up and configures the 6-axis IMU through the shared SPI master, waits for data-ready interrupts, and reads pitch-rate and Z-acceleration register pairs. It presents each completed sample as `ptch_rt`/`AZ` with a one-cycle `vld` strobe directly to `inertial_integrator`.

## Interface
- `INIT_CYCLES`, default 65535: clocks to wait after reset before the first config write (IMU power-up); benches shorten it.
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `INT`  in  1  IMU data-ready interrupt, asynchronous to `clk`
- `wrt`  out  1  one-cycle strobe starting an SPI transaction
- `cmd`  out  16  SPI command word: {R/W̄+addr[7:0], data[7:0]}
- `done`  in  1  one-cycle strobe from the SPI master marking transaction complete
- `rd_data`  in  16  SPI read-back; only [7:0] is used
- `vld`  out  1  one-cycle strobe: new `ptch_rt`/`AZ` sample
- `ptch_rt`  out  16  signed pitch rate, {high byte, low byte}
- `AZ`  out  16  signed Z acceleration, {high byte, low byte}

## Operation
- `INT` passes through a 2-flop synchronizer (`INT_ff2`). All decisions use `INT_ff2`.
- States:
  - PWR: count to `INIT_CYCLES`, then go to CFG.
  - CFG: issue config writes in order: 16'h0D02 (INT1 on data-ready), 16'h1053 (accel 208 Hz, ±2 g), 16'h1150 (gyro 208 Hz), 16'h1460 (rounding on).
  - CFG_WT: wait for `done` after each config write. After the 4th `done`, go to IDLE.
  - IDLE: wait for `INT_ff2`=1, then go to RD.
  - RD: issue reads in order: 16'hA2xx (pitch low), 16'hA3xx (pitch high), 16'hACxx (AZ low), 16'hADxx (AZ high). Low byte xx is 8'h00.
  - RD_WT: on each `done`, latch `rd_data[7:0]` into the matching holding byte. After the 4th `done`, go to IDLE.
- A 2-bit index counter steps through the 4 commands in both CFG and RD. It clears on entry to CFG and on entry to RD.
- On the 4th read `done`:
  - `ptch_rt` and `AZ` load from the holding bytes.
  - `vld`=1 for exactly that next cycle.
  - Outputs hold until the next completed sample.
- Arithmetic: none. Byte concatenation only; no sign extension, no offset removal. Offset removal belongs to the integrator.

## Timing
- Reset values:
  - State PWR, timer 0, index 0.
  - `wrt`=0, `cmd`=0, `vld`=0, `ptch_rt`=0, `AZ`=0, holding bytes 0, synchronizer flops 0.
- Exactly one transaction is outstanding at a time.
- `wrt` pulses high for exactly one cycle. `cmd` is valid in that cycle and is held stable until the matching `done`.
- The next `wrt` is no earlier than the cycle after `done`. `done` and `wrt` never share a cycle.
- `done` received while no transaction is outstanding (PWR, IDLE) is ignored.
- `INT` during PWR/CFG is ignored and does not queue.
- `INT_ff2` still high when IDLE is re-entered starts a new read sequence immediately; no edge detect.
- Latency:
  - `INT` rise to first `wrt`: ≤3 clocks (2 sync flops + IDLE→RD).
  - 4th `done` to `vld`: 1 clock.
- Reset asserted mid-sequence:
  - Immediate return to PWR. Full power-up wait and reconfiguration repeat.
  - The partially read sample is discarded and `vld` is not produced.
- Timer counts exactly `INIT_CYCLES` clocks. The first `wrt` is in cycle `INIT_CYCLES`+1 after reset release.

## Structure
- Package `inert_pkg`:
  - state enum (PWR, CFG, CFG_WT, IDLE, RD, RD_WT)
  - the four config command constants
  - the four read-address constants
- Sub-module `sync2`: generic 2-flop synchronizer with async active-low reset, instantiated for `INT`.
- The SPI master and `inertial_integrator` are siblings at the top level, not instantiated here.

## Test plan
- Reset release, `INIT_CYCLES`=16, bench SPI model returns `done` 20 clocks after each `wrt` -> first `wrt` at cycle 17; `cmd` sequence 0D02, 1053, 1150, 1460; then `wrt` stays low.
- After config, `INT` high; model returns 8'hC2, 8'h13, 8'h00, 8'h08 -> `cmd` A2xx, A3xx, ACxx, ADxx; single `vld` pulse with `ptch_rt`=16'h13C2, `AZ`=16'h0800.
- `INT` pulsed during PWR and CFG -> no read command issued until config completes.
- Spurious `done` in IDLE; `INT` held high across two samples -> spurious `done` ignored, no `wrt`; back-to-back sequences, two `vld` pulses, outputs change only at each `vld`.
- `rst_n` low after the 2nd read `done` -> outputs 0, no `vld`, PWR wait restarts, full 4-write config reissued.
- Negative sample: bytes 8'h3E, 8'hF0 for pitch -> `ptch_rt`=16'hF03E (signed −4034); previous `AZ` unchanged until `vld`.

Source files
------------

// File: rtl/inert_pkg.sv
// inert_pkg -- shared types and constants for the inertial sensor front-end.
//   state_t        : sequencer states (power-up wait, config, idle, read)
//   CFG_*          : the four IMU configuration write commands, in issue order
//   RD_*           : register addresses of the pitch-rate and Z-accel byte pairs
//   cfg_cmd/rd_cmd : map the 2-bit command index onto the 16-bit SPI word
package inert_pkg;

    typedef enum logic [2:0] {
        PWR,
        CFG,
        CFG_WT,
        IDLE,
        RD,
        RD_WT
    } state_t;

    // Configuration writes: {R/W=0 + addr, data}
    localparam logic [15:0] CFG_INT1  = 16'h0D02;  // INT1 driven by data-ready
    localparam logic [15:0] CFG_ACCEL = 16'h1053;  // accel 208 Hz, +/-2 g
    localparam logic [15:0] CFG_GYRO  = 16'h1150;  // gyro 208 Hz
    localparam logic [15:0] CFG_ROUND = 16'h1460;  // rounding on

    // Read addresses with the R/W bit already set
    localparam logic [7:0] RD_PTCH_L = 8'hA2;
    localparam logic [7:0] RD_PTCH_H = 8'hA3;
    localparam logic [7:0] RD_AZ_L   = 8'hAC;
    localparam logic [7:0] RD_AZ_H   = 8'hAD;

    function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
        logic [15:0] word;
        case (idx)
            2'd0:    word = CFG_INT1;
            2'd1:    word = CFG_ACCEL;
            2'd2:    word = CFG_GYRO;
            default: word = CFG_ROUND;
        endcase
        return word;
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [1:0] idx);
        logic [7:0] addr;
        case (idx)
            2'd0:    addr = RD_PTCH_L;
            2'd1:    addr = RD_PTCH_H;
            2'd2:    addr = RD_AZ_L;
            default: addr = RD_AZ_H;
        endcase
        return {addr, 8'h00};
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2 -- generic two-flop synchronizer for signals asynchronous to clk.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output (second flop)
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= '0;
            q   <= '0;
        end else begin
            ff1 <= d;
            q   <= ff1;
        end
    end

endmodule

// File: rtl/inert_intf.sv
// inert_intf -- IMU front-end. Waits out the IMU power-up time, writes the
// four configuration registers over the shared SPI master, then on each
// data-ready interrupt reads the pitch-rate and Z-accel byte pairs and
// presents them as one sample with a single-cycle vld strobe.
//   clk, rst_n : system clock, asynchronous active-low reset
//   INT        : IMU data-ready interrupt (asynchronous, synchronized here)
//   wrt, cmd   : one-cycle SPI start strobe and the command word it carries
//   done       : SPI transaction complete strobe
//   rd_data    : SPI read-back, low byte carries the register value
//   vld        : one-cycle strobe, ptch_rt/AZ hold a fresh sample
//   ptch_rt,AZ : {high byte, low byte} of pitch rate and Z acceleration
module inert_intf
    import inert_pkg::*;
#(
    parameter int INIT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    // Timer only has to reach INIT_CYCLES-1.
    localparam int              TW         = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(INIT_CYCLES - 1);

    state_t       state;
    logic [TW-1:0] timer;
    logic [1:0]   idx;
    logic         int_ff2;
    logic [7:0]   ptch_lo;
    logic [7:0]   ptch_hi;
    logic [7:0]   az_lo;

    // Only the low byte of the read-back is meaningful.
    logic unused_rd_hi;
    assign unused_rd_hi = &{1'b0, rd_data[15:8]};

    sync2 #(
        .WIDTH(1)
    ) u_int_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (INT),
        .q    (int_ff2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PWR;
            timer   <= '0;
            idx     <= 2'd0;
            wrt     <= 1'b0;
            cmd     <= 16'h0000;
            vld     <= 1'b0;
            ptch_rt <= 16'h0000;
            AZ      <= 16'h0000;
            ptch_lo <= 8'h00;
            ptch_hi <= 8'h00;
            az_lo   <= 8'h00;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            case (state)
                PWR: begin
                    if (timer == TIMER_LAST) begin
                        state <= CFG;
                        idx   <= 2'd0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CFG: begin
                    wrt   <= 1'b1;
                    cmd   <= cfg_cmd(idx);
                    state <= CFG_WT;
                end
                CFG_WT: begin
                    if (done) begin
                        if (idx == 2'd3) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= CFG;
                        end
                    end
                end
                IDLE: begin
                    // The first read is launched straight from IDLE so that
                    // INT-to-wrt stays at two sync flops plus one clock.
                    // Level sensitive: a still-high INT restarts at once.
                    if (int_ff2) begin
                        wrt   <= 1'b1;
                        cmd   <= rd_cmd(2'd0);
                        idx   <= 2'd0;
                        state <= RD_WT;
                    end
                end
                RD: begin
                    wrt   <= 1'b1;
                    cmd   <= rd_cmd(idx);
                    state <= RD_WT;
                end
                RD_WT: begin
                    if (done) begin
                        case (idx)
                            2'd0: ptch_lo <= rd_data[7:0];
                            2'd1: ptch_hi <= rd_data[7:0];
                            2'd2: az_lo   <= rd_data[7:0];
                            default: begin
                                // AZ high byte goes straight to the output.
                                ptch_rt <= {ptch_hi, ptch_lo};
                                AZ      <= {rd_data[7:0], az_lo};
                                vld     <= 1'b1;
                            end
                        endcase
                        if (idx == 2'd3) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= RD;
                        end
                    end
                end
                default: state <= PWR;
            endcase
        end
    end

endmodule
